fwd_mux_pipe: RTL and testbench
===============================

Name: fwd_mux_pipe

Overview:
- Parametrised, registered N-way operand-select pipeline for the EX-stage forwarding path.
- Each cycle it selects one of NUM_INPUTS WIDTH-bit candidates (register file, EX/MEM result, MEM/WB result, ...) by a select code.
- The selected value passes through STAGES pipeline registers with stall and flush control.
- It flags and counts out-of-range select codes and drives a zero operand when one occurs.

Parameters:
- WIDTH, 32, data width of each candidate and of the output.
- NUM_INPUTS, 3, number of candidates (2..8).
- SEL_W, 2, select width; must be at least ceil(log2(NUM_INPUTS)).
- STAGES, 1, pipeline depth / latency in cycles (1..4).
- CNT_W, 8, width of the saturating select-error counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_flat, input, NUM_INPUTS*WIDTH, packed candidates; candidate k occupies bits [k*WIDTH +: WIDTH].
- sel, input, SEL_W, candidate select code.
- in_valid, input, 1, the current sel/in_flat pair is a real operand.
- stall, input, 1, hold all pipeline stages.
- flush, input, 1, kill all in-flight entries.
- out, output, WIDTH, selected operand from the last stage.
- out_valid, output, 1, out is valid.
- out_sel_err, output, 1, the entry at the last stage had an out-of-range sel.
- err_count, output, CNT_W, saturating count of accepted out-of-range selects.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n = 0, every stage's data, valid and err bits are 0, so out = 0, out_valid = 0, out_sel_err = 0, and err_count = 0. Deassertion is sampled on the next clk edge. Reset mid-operation discards all in-flight entries immediately, without waiting for a clock.
- Select:
  - If sel < NUM_INPUTS, the selected value = candidate[sel].
  - If sel >= NUM_INPUTS, the selected value = 0 and the err bit = 1.
  - Selection is combinational into stage 0 only; there is no combinational path from inputs to outputs.
- Per-stage contents: data (WIDTH), valid (1), err (1). Stage STAGES-1 drives out, out_valid and out_sel_err.
- Priority per rising edge: flush > stall > advance.
- Flush: all stage valid and err bits clear to 0 and all stage data clears to 0.
  - flush and stall together: flush wins.
  - An input presented in the same cycle as flush is dropped.
- Stall (flush = 0): all stages hold and the input is not accepted. err_count does not change.
- Advance:
  - Stage 0 loads {selected value, in_valid, in_valid & err}.
  - Stage i loads stage i-1.
  - When in_valid = 0, stage 0 data still loads the selected value, but valid = 0 and err = 0; the bench must not check out while out_valid = 0.
- Latency: an operand accepted at edge n appears at out after edge n+STAGES-1, i.e. STAGES cycles after it is presented. Throughput is one per cycle when not stalled.
- err_count:
  - Increments by 1 at each advancing edge where in_valid = 1 and sel is out of range.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Not affected by flush; cleared only by reset.
- Power-of-two NUM_INPUTS with SEL_W = log2(NUM_INPUTS): out-of-range selects are impossible, so err_count stays 0.

Test Plan:
1. Selection, default params: candidates AAAAAAAA, BBBBBBBB, CCCCCCCC; in_valid = 1; sel = 0, 1, 2 on consecutive cycles. Required: out = AAAAAAAA, BBBBBBBB, CCCCCCCC, each one cycle after its sel, with out_valid = 1.
2. Out-of-range select: sel = 3 with in_valid = 1. Required: next cycle out = 00000000, out_valid = 1, out_sel_err = 1, err_count = 1. Repeat 300 times with CNT_W = 8: err_count saturates at 255.
3. Stall and flush, STAGES = 3: stream sel 0, 1, 2, then stall = 1 for 2 cycles. Required: out and out_valid frozen during the stall; after release, the remaining values emerge in order. Then flush with stall high. Required: next cycle out_valid = 0, out = 0, and the operand presented in the flush cycle never appears.
4. Asynchronous reset: rst_n low for half a cycle mid-stream (STAGES = 2). Required: out = 0, out_valid = 0 and err_count = 0 immediately, without a clock edge; the first operand after release appears 2 cycles after it is presented.
5. in_valid gaps: alternate in_valid 1/0 with sel = 1. Required: out_valid toggles 1/0 with one-cycle latency; err_count is unchanged by invalid out-of-range selects.
6. NUM_INPUTS = 4, SEL_W = 2, WIDTH = 16: sweep sel 0..3 over candidates 1111, 2222, 3333, 4444. Required: matching outputs, and out_sel_err is never set.

Source files
------------

// File: rtl/fwd_mux_if.sv
// fwd_mux_if: operand-select bus between the EX-stage forwarding pipe and its driver.
interface fwd_mux_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 8
) ();
    logic [NUM_INPUTS*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]            sel;
    logic                        in_valid;
    logic                        stall;
    logic                        flush;
    logic [WIDTH-1:0]            out;
    logic                        out_valid;
    logic                        out_sel_err;
    logic [CNT_W-1:0]            err_count;
    modport master (
        output in_flat, sel, in_valid, stall, flush,
        input  out, out_valid, out_sel_err, err_count
    );
    modport slave (
        input  in_flat, sel, in_valid, stall, flush,
        output out, out_valid, out_sel_err, err_count
    );
endinterface

// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe: registered N-way forwarding operand select with stall/flush and
// a saturating count of out-of-range select codes.
module fwd_mux_pipe #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = 2,
    parameter int STAGES     = 1,
    parameter int CNT_W      = 8
) (
    input logic        clk,
    input logic        rst_n,
    fwd_mux_if.slave   mux_io
);
    logic             sel_err;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign sel_err  = int'(mux_io.sel) >= NUM_INPUTS;
    assign sel_data = sel_err ? '0 : mux_io.in_flat[int'(mux_io.sel)*WIDTH +: WIDTH];
    // flush beats stall beats advance; the error counter only moves on an advance
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (mux_io.flush) begin
            data_d  = '{default: '0};
            valid_d = '0;
            err_d   = '0;
        end else if (!mux_io.stall) begin
            data_d[0]  = sel_data;
            valid_d[0] = mux_io.in_valid;
            err_d[0]   = mux_io.in_valid & sel_err;
            for (int i = 1; i < STAGES; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
            end
            cnt_d = (mux_io.in_valid && sel_err && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '{default: '0};
            valid_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign mux_io.out         = data_q[STAGES-1];
    assign mux_io.out_valid   = valid_q[STAGES-1];
    assign mux_io.out_sel_err = err_q[STAGES-1];
    assign mux_io.err_count   = cnt_q;
endmodule

// File: tb/tb_fwd_mux_pipe.sv
// tb_fwd_mux_pipe: three configurations of fwd_mux_pipe share one random stream and
// are checked every cycle against a history-queue model, plus directed literal checks.
module tb_fwd_mux_pipe;
    logic clk = 1'b0;
    logic rst_n, in_valid, stall, flush;
    logic [1:0] sel;
    logic [3:0][31:0] cand;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;

    fwd_mux_if #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .CNT_W(8)) ia ();
    fwd_mux_if #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .CNT_W(8)) ib ();
    fwd_mux_if #(.WIDTH(16), .NUM_INPUTS(4), .SEL_W(2), .CNT_W(8)) ic ();

    assign ia.in_flat = cand[2:0];
    assign ib.in_flat = cand[2:0];
    assign ic.in_flat = {cand[3][15:0], cand[2][15:0], cand[1][15:0], cand[0][15:0]};
    assign ia.sel = sel;       assign ib.sel = sel;       assign ic.sel = sel;
    assign ia.in_valid = in_valid; assign ib.in_valid = in_valid; assign ic.in_valid = in_valid;
    assign ia.stall = stall;   assign ib.stall = stall;   assign ic.stall = stall;
    assign ia.flush = flush;   assign ib.flush = flush;   assign ic.flush = flush;

    fwd_mux_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .STAGES(1), .CNT_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .mux_io(ia.slave));
    fwd_mux_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .STAGES(3), .CNT_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .mux_io(ib.slave));
    fwd_mux_pipe #(.WIDTH(16), .NUM_INPUTS(4), .SEL_W(2), .STAGES(2), .CNT_W(8))
        dut_c (.clk(clk), .rst_n(rst_n), .mux_io(ic.slave));

    // Model: every operand accepted since the last flush/reset, newest last.
    // A pipe of depth S shows the S-th newest entry, or all-zero if there is none.
    typedef struct packed {
        logic             v;
        logic [1:0]       s;
        logic [3:0][31:0] c;
    } ent_t;
    ent_t hist[$];
    int ecnt[3];

    always @(posedge clk or negedge rst_n) begin
        ent_t e;
        if (!rst_n) begin
            hist.delete();
            ecnt = '{0, 0, 0};
        end else if (flush) begin
            hist.delete();
        end else if (!stall) begin
            e.v = in_valid;
            e.s = sel;
            e.c = cand;
            hist.push_back(e);
            if (hist.size() > 4) void'(hist.pop_front());
            for (int k = 0; k < 3; k++)
                if (in_valid && int'(sel) >= ((k == 2) ? 4 : 3) && ecnt[k] < 255) ecnt[k]++;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_dut(string nm, int n, int w, int st, int k,
                           logic [31:0] o, logic ov, logic oe, logic [7:0] oc);
        ent_t h;
        logic ev, ee;
        logic [31:0] ed, m;
        m  = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        ev = 1'b0;
        ee = 1'b0;
        ed = '0;
        if (hist.size() >= st) begin
            h  = hist[hist.size()-st];
            ev = h.v;
            ee = h.v && int'(h.s) >= n;
            ed = (int'(h.s) >= n) ? 32'd0 : (h.c[h.s] & m);
        end
        chk({nm, ".out_valid"}, 32'(ov), 32'(ev));
        chk({nm, ".out_sel_err"}, 32'(oe), 32'(ee));
        chk({nm, ".err_count"}, 32'(oc), ecnt[k]);
        if (ev || hist.size() < st) chk({nm, ".out"}, o, ed);
    endtask

    always @(negedge clk) begin
        cmp_dut("A", 3, 32, 1, 0, ia.out, ia.out_valid, ia.out_sel_err, ia.err_count);
        cmp_dut("B", 3, 32, 3, 1, ib.out, ib.out_valid, ib.out_sel_err, ib.err_count);
        cmp_dut("C", 4, 16, 2, 2, 32'(ic.out), ic.out_valid, ic.out_sel_err, ic.err_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        {in_valid, stall, flush, sel} = '0;
        cand = '{32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        #1 rst_n = 1'b0;
        step();
        chk("rst.out", ia.out, 32'h0);
        chk("rst.out_valid", 32'(ia.out_valid), 32'h0);
        chk("rst.err_count", 32'(ia.err_count), 32'h0);
        rst_n = 1'b1;
        step();
        // selection, one-cycle latency
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            step();
            chk("sel.out", ia.out, (k == 0) ? 32'hAAAA_AAAA : (k == 1) ? 32'hBBBB_BBBB : 32'hCCCC_CCCC);
            chk("sel.valid", 32'(ia.out_valid), 32'h1);
        end
        // valid gaps; invalid out-of-range selects leave the counter alone
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            sel = in_valid ? 2'd1 : 2'd3;
            step();
            chk("gap.valid", 32'(ia.out_valid), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("gap.err_count", 32'(ia.err_count), 32'h0);
        end
        // out-of-range select and counter saturation
        in_valid = 1'b1;
        sel = 2'd3;
        step();
        chk("oor.out", ia.out, 32'h0);
        chk("oor.sel_err", 32'(ia.out_sel_err), 32'h1);
        chk("oor.err_count", 32'(ia.err_count), 32'h1);
        repeat (299) step();
        chk("sat.err_count", 32'(ia.err_count), 32'd255);
        chk("sat.c_err_count", 32'(ic.err_count), 32'h0);
        chk("sat.c_out", 32'(ic.out), 32'hDDDD);
        // stall and flush on the 3-deep pipe
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            step();
        end
        chk("st.out0", ib.out, 32'hAAAA_AAAA);
        stall = 1'b1;
        sel = 2'd0;
        repeat (2) begin
            step();
            chk("st.hold", ib.out, 32'hAAAA_AAAA);
            chk("st.hold_v", 32'(ib.out_valid), 32'h1);
        end
        stall = 1'b0;
        in_valid = 1'b0;
        step();
        chk("st.out1", ib.out, 32'hBBBB_BBBB);
        step();
        chk("st.out2", ib.out, 32'hCCCC_CCCC);
        in_valid = 1'b1;
        sel = 2'd1;
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("fl.valid", 32'(ib.out_valid), 32'h0);
        chk("fl.out", ib.out, 32'h0);
        {flush, stall, in_valid} = '0;
        repeat (3) begin
            step();
            chk("fl.drop", 32'(ib.out_valid), 32'h0);
        end
        // asynchronous reset mid-stream
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            step();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("ar.out", 32'(ic.out), 32'h0);
        chk("ar.valid", 32'(ic.out_valid), 32'h0);
        chk("ar.err_count", 32'(ia.err_count), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cand[1] = 32'h1234_5678;
        sel = 2'd1;
        in_valid = 1'b1;
        step();
        chk("ar.lat1", 32'(ic.out_valid), 32'h0);
        in_valid = 1'b0;
        step();
        chk("ar.lat2_v", 32'(ic.out_valid), 32'h1);
        chk("ar.lat2", 32'(ic.out), 32'h5678);
        // four-way sweep on the 16-bit pipe
        for (int k = 0; k < 4; k++) cand[k] = 32'h1111_1111 * (k + 1);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sel = 2'(k);
            in_valid = (k < 4);
            step();
            if (k > 0) begin
                chk("sw.out", 32'(ic.out), 32'h1111 * k);
                chk("sw.sel_err", 32'(ic.out_sel_err), 32'h0);
            end
        end
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 4; k++) cand[k] = $urandom;
            sel = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        {in_valid, stall, flush} = '0;
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
